pattern_scan_ctrl: RTL and testbench

Controller that arms, configures and sequences a programmable serial bit-pattern detector on a 1-bit data stream. It latches a pattern, length, match target and timeout from a config port. On start it scans qualified input bits and counts pattern hits. It terminates with a done pulse (target reached), a timeout_err pulse (no hit within the window) or an abort. It sits between the control/register logic and the raw serial data path and replaces hard-wired single-pattern detectors.

---
 rtl/pattern_scan_pkg.sv | 35 +++
 rtl/pattern_scan_if.sv | 45 ++++
 rtl/pattern_window.sv | 61 ++++++
 rtl/pattern_scan_ctrl.sv | 172 +++++++++++++++++
 tb/tb_pattern_scan_ctrl.sv | 439 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pattern_scan_pkg.sv
// pattern_scan_pkg
//   Shared definitions for the programmable serial pattern-scan controller:
//   controller state encoding (one-hot), default field widths and the
//   clamping helpers applied to configuration fields when they are latched.
package pattern_scan_pkg;

    // One-hot controller states.
    typedef enum logic [2:0] {
        ST_IDLE   = 3'b001,
        ST_SCAN   = 3'b010,
        ST_FINISH = 3'b100
    } state_t;

    // Default field widths.
    localparam int unsigned PAT_W_DEF = 8;   // maximum pattern length in bits
    localparam int unsigned CNT_W_DEF = 8;   // match target / match counter width
    localparam int unsigned TMO_W_DEF = 16;  // timeout counter width

    // Pattern length: 0 behaves as 1, anything above max_len behaves as max_len.
    function automatic int unsigned clamp_len(input int unsigned len,
                                              input int unsigned max_len);
        if (len == 0) begin
            return 1;
        end else if (len > max_len) begin
            return max_len;
        end
        return len;
    endfunction

    // Match target: 0 behaves as 1.
    function automatic int unsigned clamp_min1(input int unsigned value);
        return (value == 0) ? 1 : value;
    endfunction

endpackage

// File: rtl/pattern_scan_if.sv
// pattern_scan_if
//   Bundles the configuration port, scan control, serial data input and
//   status outputs of pattern_scan_ctrl.
//   master : control/register side (drives cfg_*, start, abort, data_valid, data)
//   slave  : pattern_scan_ctrl (drives busy, match, match_cnt, done, timeout_err)
//   Signals:
//     cfg_we, cfg_pat, cfg_len, cfg_target, cfg_overlap, cfg_timeout - config write
//     start, abort            - scan control
//     data_valid, data        - qualified serial bit stream
//     busy, match, match_cnt, done, timeout_err - status
interface pattern_scan_if #(
    parameter int unsigned PAT_W = 8,
    parameter int unsigned LEN_W = $clog2(PAT_W + 1),
    parameter int unsigned CNT_W = 8,
    parameter int unsigned TMO_W = 16
);
    logic             cfg_we;
    logic [PAT_W-1:0] cfg_pat;
    logic [LEN_W-1:0] cfg_len;
    logic [CNT_W-1:0] cfg_target;
    logic             cfg_overlap;
    logic [TMO_W-1:0] cfg_timeout;
    logic             start;
    logic             abort;
    logic             data_valid;
    logic             data;
    logic             busy;
    logic             match;
    logic [CNT_W-1:0] match_cnt;
    logic             done;
    logic             timeout_err;

    modport master (
        output cfg_we, cfg_pat, cfg_len, cfg_target, cfg_overlap, cfg_timeout,
        output start, abort, data_valid, data,
        input  busy, match, match_cnt, done, timeout_err
    );

    modport slave (
        input  cfg_we, cfg_pat, cfg_len, cfg_target, cfg_overlap, cfg_timeout,
        input  start, abort, data_valid, data,
        output busy, match, match_cnt, done, timeout_err
    );

endinterface

// File: rtl/pattern_window.sv
// pattern_window
//   Serial shift window with a saturating count of bits seen since the last
//   restart and a length-masked compare against the programmed pattern.
//   Ports:
//     clk, rst  - clock, synchronous active-high reset
//     clr       - clears window and bit count (scan start)
//     shift     - a qualified bit is present on data this cycle
//     data      - serial bit
//     pat, len  - pattern and (already clamped) length
//     restart   - restart bit counting after this edge (non-overlap hit)
//     hit       - combinational: the window including this bit matches
module pattern_window #(
    parameter int unsigned PAT_W = 8,
    parameter int unsigned LEN_W = $clog2(PAT_W + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             shift,
    input  logic             data,
    input  logic [PAT_W-1:0] pat,
    input  logic [LEN_W-1:0] len,
    input  logic             restart,
    output logic             hit
);

    logic [PAT_W-1:0] win;
    logic [PAT_W-1:0] win_next;
    logic [PAT_W-1:0] mask;
    logic [LEN_W-1:0] bits_seen;

    // The newest bit enters at bit 0, so the last len bits received line up
    // with pat[len-1:0] (pat[len-1] being the oldest of them).
    always_comb begin
        win_next = {win[PAT_W-2:0], data};
        mask     = '0;
        for (int unsigned i = 0; i < PAT_W; i++) begin
            mask[i] = (i < 32'(len));
        end
        hit = shift
            && ((32'(bits_seen) + 32'd1) >= 32'(len))
            && (((win_next ^ pat) & mask) == '0);
    end

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            win       <= '0;
            bits_seen <= '0;
        end else if (shift) begin
            win <= win_next;
            // After a non-overlapping hit the old bits stay in the window but
            // are not counted, so they cannot contribute to the next hit.
            if (restart) begin
                bits_seen <= '0;
            end else if (bits_seen < len) begin
                bits_seen <= bits_seen + 1'b1;
            end
        end
    end

endmodule

// File: rtl/pattern_scan_ctrl.sv
// pattern_scan_ctrl
//   Arms, configures and sequences a programmable serial bit-pattern detector.
//   Configuration is latched only while idle; a scan counts pattern hits and
//   ends with done (target reached), timeout_err (no hit within the window)
//   or an abort (no pulse).
//   Ports:
//     clk  - clock, rising edge
//     rst  - synchronous active-high reset
//     bus  - pattern_scan_if.slave: config, start/abort, data stream, status
module pattern_scan_ctrl
    import pattern_scan_pkg::*;
#(
    parameter int unsigned PAT_W = PAT_W_DEF,
    parameter int unsigned LEN_W = $clog2(PAT_W + 1),
    parameter int unsigned CNT_W = CNT_W_DEF,
    parameter int unsigned TMO_W = TMO_W_DEF
) (
    input logic           clk,
    input logic           rst,
    pattern_scan_if.slave bus
);

    typedef struct packed {
        logic [PAT_W-1:0] pat;
        logic [LEN_W-1:0] len;
        logic [CNT_W-1:0] target;
        logic             overlap;
        logic [TMO_W-1:0] timeout;
    } cfg_t;

    localparam logic [CNT_W:0] CNT_ONE = (CNT_W + 1)'(1);

    state_t           state;
    state_t           state_next;
    cfg_t             cfg_q;
    logic [CNT_W-1:0] match_cnt;
    logic [TMO_W-1:0] timer;
    logic             match_q;
    logic             done_q;
    logic             tmo_q;

    logic             cfg_take;
    logic             start_scan;
    logic             scan_go;
    logic             shift;
    logic             hit;
    logic             term_hit;
    logic             tmo_fire;
    logic [CNT_W-1:0] cnt_inc;

    // ------------------------------------------------------------------
    // Window / compare datapath
    // ------------------------------------------------------------------
    pattern_window #(
        .PAT_W (PAT_W),
        .LEN_W (LEN_W)
    ) u_window (
        .clk     (clk),
        .rst     (rst),
        .clr     (start_scan),
        .shift   (shift),
        .data    (bus.data),
        .pat     (cfg_q.pat),
        .len     (cfg_q.len),
        .restart (hit && !cfg_q.overlap),
        .hit     (hit)
    );

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state and scan qualifiers
    // ------------------------------------------------------------------
    always_comb begin
        state_next = state;
        cfg_take   = (state == ST_IDLE) && bus.cfg_we;
        start_scan = (state == ST_IDLE) && bus.start;
        // abort outranks everything: it blocks shifting, hits and timeout.
        scan_go    = (state == ST_SCAN) && !bus.abort;
        shift      = scan_go && bus.data_valid;
        cnt_inc    = (match_cnt == '1) ? match_cnt : match_cnt + 1'b1;
        term_hit   = hit && (({1'b0, match_cnt} + CNT_ONE) >= {1'b0, cfg_q.target});
        // A hit on the same edge wins over the timeout.
        tmo_fire   = scan_go
                  && (cfg_q.timeout != '0)
                  && (timer == cfg_q.timeout - 1'b1)
                  && !hit;

        case (state)
            ST_IDLE: begin
                if (bus.start) begin
                    state_next = ST_SCAN;
                end
            end
            ST_SCAN: begin
                if (bus.abort) begin
                    state_next = ST_IDLE;
                end else if (term_hit || tmo_fire) begin
                    state_next = ST_FINISH;
                end
            end
            ST_FINISH: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Configuration registers (clamped at latch time)
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            cfg_q.pat     <= '0;
            cfg_q.len     <= LEN_W'(PAT_W);
            cfg_q.target  <= CNT_W'(1);
            cfg_q.overlap <= 1'b1;
            cfg_q.timeout <= '0;
        end else if (cfg_take) begin
            cfg_q.pat     <= bus.cfg_pat;
            cfg_q.len     <= LEN_W'(clamp_len(32'(bus.cfg_len), PAT_W));
            cfg_q.target  <= CNT_W'(clamp_min1(32'(bus.cfg_target)));
            cfg_q.overlap <= bus.cfg_overlap;
            cfg_q.timeout <= bus.cfg_timeout;
        end
    end

    // ------------------------------------------------------------------
    // Match counter, timer and status pulses
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            match_cnt <= '0;
            timer     <= '0;
            match_q   <= 1'b0;
            done_q    <= 1'b0;
            tmo_q     <= 1'b0;
        end else begin
            match_q <= hit;
            done_q  <= term_hit;
            tmo_q   <= tmo_fire;
            if (start_scan) begin
                match_cnt <= '0;
                timer     <= '0;
            end else if (hit) begin
                match_cnt <= cnt_inc;
                timer     <= '0;
            end else if (scan_go) begin
                timer <= timer + 1'b1;
            end
        end
    end

    // busy covers FINISH so it falls one cycle after the terminating pulse.
    assign bus.busy        = (state != ST_IDLE);
    assign bus.match       = match_q;
    assign bus.match_cnt   = match_cnt;
    assign bus.done        = done_q;
    assign bus.timeout_err = tmo_q;

endmodule

// File: tb/tb_pattern_scan_ctrl.sv
// tb_pattern_scan_ctrl
//   Self-checking bench for pattern_scan_ctrl. Each scenario queues per-cycle
//   stimulus and the expected status word {match,done,timeout_err,busy,cnt}
//   for that cycle; expectations are popped and compared after each edge.
module tb_pattern_scan_ctrl;

    localparam int unsigned PAT_W = 8;
    localparam int unsigned LEN_W = 4;
    localparam int unsigned CNT_W = 8;
    localparam int unsigned TMO_W = 16;

    typedef struct packed {
        logic v;
        logic d;
        logic we;
        logic st;
        logic ab;
    } stim_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   errors = 0;
    int   checks = 0;

    stim_t       sq[$];
    logic [11:0] sb[$];

    pattern_scan_if #(
        .PAT_W (PAT_W),
        .LEN_W (LEN_W),
        .CNT_W (CNT_W),
        .TMO_W (TMO_W)
    ) bus ();

    pattern_scan_ctrl #(
        .PAT_W (PAT_W),
        .LEN_W (LEN_W),
        .CNT_W (CNT_W),
        .TMO_W (TMO_W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    function automatic stim_t mk(input logic v, input logic d, input logic we,
                                 input logic st, input logic ab);
        return {v, d, we, st, ab};
    endfunction

    function automatic logic [11:0] ex(input logic m, input logic d, input logic t,
                                       input logic b, input logic [7:0] c);
        return {m, d, t, b, c};
    endfunction

    function automatic logic [11:0] obs();
        return {bus.match, bus.done, bus.timeout_err, bus.busy, bus.match_cnt};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply(input stim_t s);
        bus.data_valid = s.v;
        bus.data       = s.d;
        bus.cfg_we     = s.we;
        bus.start      = s.st;
        bus.abort      = s.ab;
    endtask

    task automatic idle_inputs();
        bus.data_valid = 1'b0;
        bus.data       = 1'b0;
        bus.cfg_we     = 1'b0;
        bus.start      = 1'b0;
        bus.abort      = 1'b0;
    endtask

    task automatic set_cfg(input logic [7:0] pat, input logic [3:0] len,
                           input logic [7:0] target, input logic overlap,
                           input logic [15:0] timeout);
        bus.cfg_pat     = pat;
        bus.cfg_len     = len;
        bus.cfg_target  = target;
        bus.cfg_overlap = overlap;
        bus.cfg_timeout = timeout;
        bus.cfg_we      = 1'b1;
        tick();
        bus.cfg_we      = 1'b0;
    endtask

    task automatic pulse_start();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
    endtask

    task automatic test_reset();
        logic [11:0] o;
        idle_inputs();
        bus.cfg_pat = '0; bus.cfg_len = '0; bus.cfg_target = '0;
        bus.cfg_overlap = 1'b0; bus.cfg_timeout = '0;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        o = obs();
        checks++;
        if (o !== 12'h000) begin
            errors++;
            $display("FAIL reset: got {m,d,t,busy}=%b cnt=%0d want 0000 cnt=0", o[11:8], o[7:0]);
        end
    endtask

    // 1011 with overlap: hits after bits 4 and 7; start in FINISH is ignored.
    task automatic test_overlap();
        logic [6:0]  bits;
        stim_t       s;
        logic [11:0] e, o;
        int          idx;
        bits = 7'b1011011;
        set_cfg(8'b0000_1011, 4'd4, 8'd2, 1'b1, 16'd0);
        pulse_start();
        checks++;
        if (bus.busy !== 1'b1) begin
            errors++;
            $display("FAIL start_busy: got %b want 1", bus.busy);
        end
        for (int i = 0; i < 7; i++) begin
            sq.push_back(mk(1'b1, bits[6-i], 1'b0, 1'b0, 1'b0));
            sb.push_back(ex(i == 3 || i == 6, i == 6, 1'b0, 1'b1,
                            (i >= 6) ? 8'd2 : (i >= 3) ? 8'd1 : 8'd0));
        end
        sq.push_back(mk(1'b0, 1'b0, 1'b0, 1'b1, 1'b0));
        sb.push_back(ex(1'b0, 1'b0, 1'b0, 1'b0, 8'd2));
        sq.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
        sb.push_back(ex(1'b0, 1'b0, 1'b0, 1'b0, 8'd2));
        idx = 0;
        while (sq.size() != 0) begin
            s = sq.pop_front();
            apply(s);
            tick();
            idle_inputs();
            e = sb.pop_front();
            o = obs();
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL overlap[%0d]: got {m,d,t,busy}=%b cnt=%0d want %b cnt=%0d",
                         idx, o[11:8], o[7:0], e[11:8], e[7:0]);
            end
            idx++;
        end
    endtask

    // Same stream without overlap: only the first 1011 counts.
    task automatic test_no_overlap();
        logic [6:0]  bits;
        stim_t       s;
        logic [11:0] e, o;
        int          idx;
        bits = 7'b1011011;
        set_cfg(8'b0000_1011, 4'd4, 8'd2, 1'b0, 16'd0);
        pulse_start();
        for (int i = 0; i < 7; i++) begin
            sq.push_back(mk(1'b1, bits[6-i], 1'b0, 1'b0, 1'b0));
            sb.push_back(ex(i == 3, 1'b0, 1'b0, 1'b1, (i >= 3) ? 8'd1 : 8'd0));
        end
        for (int i = 0; i < 2; i++) begin
            sq.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
            sb.push_back(ex(1'b0, 1'b0, 1'b0, 1'b1, 8'd1));
        end
        sq.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1));
        sb.push_back(ex(1'b0, 1'b0, 1'b0, 1'b0, 8'd1));
        idx = 0;
        while (sq.size() != 0) begin
            s = sq.pop_front();
            apply(s);
            tick();
            idle_inputs();
            e = sb.pop_front();
            o = obs();
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL no_overlap[%0d]: got {m,d,t,busy}=%b cnt=%0d want %b cnt=%0d",
                         idx, o[11:8], o[7:0], e[11:8], e[7:0]);
            end
            idx++;
        end
    endtask

    // Config and start on the same edge; zeros never match 101, timeout=5.
    task automatic test_timeout();
        stim_t       s;
        logic [11:0] e, o;
        int          idx;
        bus.cfg_pat     = 8'b0000_0101;
        bus.cfg_len     = 4'd3;
        bus.cfg_target  = 8'd1;
        bus.cfg_overlap = 1'b1;
        bus.cfg_timeout = 16'd5;
        bus.cfg_we      = 1'b1;
        bus.start       = 1'b1;
        tick();
        idle_inputs();
        for (int i = 0; i < 6; i++) begin
            sq.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
            sb.push_back(ex(1'b0, 1'b0, i == 4, i < 5, 8'd0));
        end
        idx = 0;
        while (sq.size() != 0) begin
            s = sq.pop_front();
            apply(s);
            tick();
            idle_inputs();
            e = sb.pop_front();
            o = obs();
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL timeout[%0d]: got {m,d,t,busy}=%b cnt=%0d want %b cnt=%0d",
                         idx, o[11:8], o[7:0], e[11:8], e[7:0]);
            end
            idx++;
        end
    endtask

    // 1,0,1,1 separated by 3 invalid cycles carrying data=1.
    task automatic test_gaps();
        logic [3:0]  bits;
        stim_t       s;
        logic [11:0] e, o;
        int          idx;
        bits = 4'b1011;
        set_cfg(8'b0000_1011, 4'd4, 8'd1, 1'b1, 16'd0);
        pulse_start();
        for (int k = 0; k < 4; k++) begin
            sq.push_back(mk(1'b1, bits[3-k], 1'b0, 1'b0, 1'b0));
            sb.push_back(ex(k == 3, k == 3, 1'b0, 1'b1, (k == 3) ? 8'd1 : 8'd0));
            if (k < 3) begin
                for (int g = 0; g < 3; g++) begin
                    sq.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0));
                    sb.push_back(ex(1'b0, 1'b0, 1'b0, 1'b1, 8'd0));
                end
            end
        end
        for (int i = 0; i < 2; i++) begin
            sq.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
            sb.push_back(ex(1'b0, 1'b0, 1'b0, 1'b0, 8'd1));
        end
        idx = 0;
        while (sq.size() != 0) begin
            s = sq.pop_front();
            apply(s);
            tick();
            idle_inputs();
            e = sb.pop_front();
            o = obs();
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL gaps[%0d]: got {m,d,t,busy}=%b cnt=%0d want %b cnt=%0d",
                         idx, o[11:8], o[7:0], e[11:8], e[7:0]);
            end
            idx++;
        end
    endtask

    // target=3: one hit, a cfg_we (target=1) during SCAN, abort; then a
    // rescan shows the target is still 3 (no done on the first hit).
    task automatic test_abort();
        logic [3:0]  bits;
        stim_t       s;
        logic [11:0] e, o;
        int          idx;
        bits = 4'b1011;
        set_cfg(8'b0000_1011, 4'd4, 8'd3, 1'b1, 16'd0);
        pulse_start();
        bus.cfg_target = 8'd1;
        for (int k = 0; k < 4; k++) begin
            sq.push_back(mk(1'b1, bits[3-k], 1'b0, 1'b0, 1'b0));
            sb.push_back(ex(k == 3, 1'b0, 1'b0, 1'b1, (k == 3) ? 8'd1 : 8'd0));
        end
        sq.push_back(mk(1'b0, 1'b0, 1'b1, 1'b0, 1'b0));
        sb.push_back(ex(1'b0, 1'b0, 1'b0, 1'b1, 8'd1));
        sq.push_back(mk(1'b1, 1'b1, 1'b0, 1'b0, 1'b1));
        sb.push_back(ex(1'b0, 1'b0, 1'b0, 1'b0, 8'd1));
        sq.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
        sb.push_back(ex(1'b0, 1'b0, 1'b0, 1'b0, 8'd1));
        sq.push_back(mk(1'b0, 1'b0, 1'b0, 1'b1, 1'b0));
        sb.push_back(ex(1'b0, 1'b0, 1'b0, 1'b1, 8'd0));
        for (int k = 0; k < 4; k++) begin
            sq.push_back(mk(1'b1, bits[3-k], 1'b0, 1'b0, 1'b0));
            sb.push_back(ex(k == 3, 1'b0, 1'b0, 1'b1, (k == 3) ? 8'd1 : 8'd0));
        end
        sq.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1));
        sb.push_back(ex(1'b0, 1'b0, 1'b0, 1'b0, 8'd1));
        idx = 0;
        while (sq.size() != 0) begin
            s = sq.pop_front();
            apply(s);
            tick();
            idle_inputs();
            e = sb.pop_front();
            o = obs();
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL abort[%0d]: got {m,d,t,busy}=%b cnt=%0d want %b cnt=%0d",
                         idx, o[11:8], o[7:0], e[11:8], e[7:0]);
            end
            idx++;
        end
    endtask

    // rst mid-scan (on the edge that would complete a hit), reset-default
    // config (pat=0, len=8, target=1), then len=0/target=0 clamping.
    task automatic test_reset_and_clamp();
        logic [3:0]  bits;
        stim_t       s;
        logic [11:0] e, o;
        int          idx;
        bits = 4'b1011;
        set_cfg(8'b0000_1011, 4'd4, 8'd2, 1'b1, 16'd0);
        pulse_start();
        for (int k = 0; k < 3; k++) begin
            sq.push_back(mk(1'b1, bits[3-k], 1'b0, 1'b0, 1'b0));
            sb.push_back(ex(1'b0, 1'b0, 1'b0, 1'b1, 8'd0));
        end
        idx = 0;
        while (sq.size() != 0) begin
            s = sq.pop_front();
            apply(s);
            tick();
            idle_inputs();
            e = sb.pop_front();
            o = obs();
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL rst_pre[%0d]: got {m,d,t,busy}=%b cnt=%0d want %b cnt=%0d",
                         idx, o[11:8], o[7:0], e[11:8], e[7:0]);
            end
            idx++;
        end
        bus.data_valid = 1'b1;
        bus.data       = 1'b1;
        rst            = 1'b1;
        tick();
        rst = 1'b0;
        idle_inputs();
        o = obs();
        checks++;
        if (o !== 12'h000) begin
            errors++;
            $display("FAIL rst_scan: got {m,d,t,busy}=%b cnt=%0d want 0000 cnt=0", o[11:8], o[7:0]);
        end
        tick();
        o = obs();
        checks++;
        if (o !== 12'h000) begin
            errors++;
            $display("FAIL rst_after: got {m,d,t,busy}=%b cnt=%0d want 0000 cnt=0", o[11:8], o[7:0]);
        end

        pulse_start();
        for (int k = 0; k < 8; k++) begin
            sq.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
            sb.push_back(ex(k == 7, k == 7, 1'b0, 1'b1, (k == 7) ? 8'd1 : 8'd0));
        end
        sq.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
        sb.push_back(ex(1'b0, 1'b0, 1'b0, 1'b0, 8'd1));
        idx = 0;
        while (sq.size() != 0) begin
            s = sq.pop_front();
            apply(s);
            tick();
            idle_inputs();
            e = sb.pop_front();
            o = obs();
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL defaults[%0d]: got {m,d,t,busy}=%b cnt=%0d want %b cnt=%0d",
                         idx, o[11:8], o[7:0], e[11:8], e[7:0]);
            end
            idx++;
        end

        set_cfg(8'b0000_0001, 4'd0, 8'd0, 1'b1, 16'd0);
        pulse_start();
        sq.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
        sb.push_back(ex(1'b0, 1'b0, 1'b0, 1'b1, 8'd0));
        sq.push_back(mk(1'b1, 1'b1, 1'b0, 1'b0, 1'b0));
        sb.push_back(ex(1'b1, 1'b1, 1'b0, 1'b1, 8'd1));
        sq.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
        sb.push_back(ex(1'b0, 1'b0, 1'b0, 1'b0, 8'd1));
        idx = 0;
        while (sq.size() != 0) begin
            s = sq.pop_front();
            apply(s);
            tick();
            idle_inputs();
            e = sb.pop_front();
            o = obs();
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL clamp[%0d]: got {m,d,t,busy}=%b cnt=%0d want %b cnt=%0d",
                         idx, o[11:8], o[7:0], e[11:8], e[7:0]);
            end
            idx++;
        end
    endtask

    initial begin
        test_reset();
        test_overlap();
        test_no_overlap();
        test_timeout();
        test_gaps();
        test_abort();
        test_reset_and_clamp();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
        $fatal(1);
    end

endmodule
